// File: rtl/keypad_matrix_scan.sv
// 4x4 active-low keypad scanner: rotates a single low row, samples the synchronised
// columns once per row slot, and debounces presses and releases before reporting a key.
module keypad_matrix_scan #(
   parameter int SCAN_DIV = 100,
   parameter int DEB_N    = 20
) (
   input  logic       clk100khz,
   input  logic       rst_n,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int SLOT_W  = $clog2(SCAN_DIV);
   localparam int MATCH_W = $clog2(DEB_N + 1);
   localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEB_N);
   localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

   typedef enum logic [1:0] {
      SCAN      = 2'd0,
      DEB_PRESS = 2'd1,
      HELD      = 2'd2
   } state_e;

   state_e               state_q;
   logic [3:0]           col_meta_q;
   logic [3:0]           col_s_q;
   logic [SLOT_W-1:0]    slot_q;
   logic [SLOT_W-1:0]    slot_d;
   logic [MATCH_W-1:0]   match_q;
   logic [MATCH_W-1:0]   match_d;
   logic [3:0]           cand_q;
   logic [3:0]           row_q;
   logic [3:0]           row_d;
   logic [3:0]           key_code_q;
   logic                 key_valid_q;
   logic                 key_held_q;

   logic                 tick;
   logic                 hit;
   logic                 idle;
   logic                 match_done;
   logic [1:0]           col_idx;
   logic [1:0]           row_idx;

   // Columns are asynchronous to the scan clock; the synchroniser idles high.
   always_ff @(posedge clk100khz or negedge rst_n) begin
      if (!rst_n) begin
         col_meta_q <= 4'b1111;
         col_s_q    <= 4'b1111;
      end else begin
         col_meta_q <= col;
         col_s_q    <= col_meta_q;
      end
   end

   always_comb begin
      tick   = (slot_q == SLOT_LAST);
      slot_d = tick ? '0 : slot_q + 1'b1;
      row_d  = {row_q[2:0], row_q[3]};

      hit     = 1'b1;
      col_idx = 2'd0;
      case (col_s_q)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: hit = 1'b0;
      endcase
      idle = (col_s_q == 4'b1111);

      row_idx = 2'd0;
      case (row_q)
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase

      match_d    = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
      match_done = (match_d == MATCH_MAX);
   end

   // Row is frozen while a key is being debounced or held; otherwise it advances per tick.
   always_ff @(posedge clk100khz or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SCAN;
         slot_q      <= '0;
         match_q     <= '0;
         cand_q      <= 4'd0;
         row_q       <= 4'b1110;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         key_valid_q <= 1'b0;
         if (tick) begin
            case (state_q)
               SCAN: begin
                  if (hit) begin
                     cand_q <= {row_idx, col_idx};
                     if (DEB_N == 1) begin
                        key_code_q  <= {row_idx, col_idx};
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        match_q     <= '0;
                        state_q     <= HELD;
                     end else begin
                        match_q <= MATCH_ONE;
                        state_q <= DEB_PRESS;
                     end
                  end else begin
                     row_q <= row_d;
                  end
               end
               DEB_PRESS: begin
                  if (hit && (col_idx == cand_q[1:0])) begin
                     if (match_done) begin
                        key_code_q  <= cand_q;
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        match_q     <= '0;
                        state_q     <= HELD;
                     end else begin
                        match_q <= match_d;
                     end
                  end else begin
                     match_q <= '0;
                     state_q <= SCAN;
                     row_q   <= row_d;
                  end
               end
               HELD: begin
                  if (idle) begin
                     if (match_done) begin
                        key_held_q <= 1'b0;
                        match_q    <= '0;
                        state_q    <= SCAN;
                        row_q      <= row_d;
                     end else begin
                        match_q <= match_d;
                     end
                  end else begin
                     match_q <= '0;
                  end
               end
               default: begin
                  match_q <= '0;
                  state_q <= SCAN;
               end
            endcase
         end
      end
   end

   assign row       = row_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: doc/keypad_matrix_scan.md
Name: keypad_matrix_scan

Overview:
- Scans a 4x4 active-low matrix keypad by driving one row low at a time and reading the four column lines.
- Debounces presses and releases.
- Emits a 4-bit key code with a one-cycle valid strobe, plus a held level.
- Sits between the board keypad pins and the digit-entry/display logic; it is the source side of the key-input path.

Parameters:
- SCAN_DIV, 100: clk100khz cycles per row slot (1 ms at 100 kHz); minimum 2.
- DEB_N, 20: consecutive identical slot samples required to accept a press or a release; minimum 1.

Ports:
- clk100khz  input  1  system clock, 100 kHz.
- rst_n  input  1  asynchronous active-low reset.
- col  input  4  keypad column lines, active-low, externally pulled up; asynchronous to clk100khz.
- row  output  4  keypad row drive, active-low; exactly one bit low at all times after reset.
- key_code  output  4  last accepted key, row_index*4 + col_index.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high from acceptance until release is accepted.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - row=4'b1110 (row 0 driven).
  - key_code=0, key_valid=0, key_held=0.
  - State SCAN; slot counter=0; match counter=0.
- Column synchronisation: col passes through a 2-flop synchroniser. All decisions use the synchronised value col_s.
- Slot timing:
  - The slot counter counts 0..SCAN_DIV-1 and wraps.
  - A "tick" is the cycle where slot counter = SCAN_DIV-1. col_s is sampled only on ticks, which gives settling time after each row change.
- Sample decode on a tick:
  - Exactly one col_s bit low = hit; col_index = position of that bit.
  - All bits high = idle.
  - Two or more bits low = invalid, treated as idle (no ghost/multi-key support).
- SCAN state:
  - Idle on a tick: row rotates to the next row on the following cycle (0→1→2→3→0).
  - Hit on a tick: latch candidate code = current_row*4+col_index, set match counter=1, row is held. If DEB_N=1, accept immediately; otherwise go to DEB_PRESS.
- DEB_PRESS state (row held):
  - Each tick with a hit on the same column increments the match counter.
  - When the counter reaches DEB_N, the key is accepted:
    - key_code <= candidate.
    - key_valid=1 for exactly the next cycle.
    - key_held=1.
    - Go to HELD with match counter=0.
  - A tick with idle, invalid, or a different column: abandon the candidate, clear the match counter, go to SCAN and advance to the next row. No strobe.
- HELD state (row held):
  - Each idle tick increments the match counter; any non-idle tick clears it.
  - When the counter reaches DEB_N: key_held=0, go to SCAN, advance to the next row.
  - key_code keeps its value until the next acceptance.
- Other rules:
  - key_valid is never high for two consecutive cycles.
  - A held key produces no repeat strobes.
  - A second key pressed while in HELD is ignored until release is accepted.
  - Reset asserted mid-debounce or mid-hold: all state returns immediately to reset values, no strobe. After rst_n release, scanning restarts at row 0 with slot counter 0.
- Width rules:
  - Match counter width = clog2(DEB_N+1); saturates at DEB_N.
  - Slot counter width = clog2(SCAN_DIV).
- Latency:
  - First tick seeing the key → key_valid = (DEB_N-1)*SCAN_DIV + 1 cycles, with the key stable.
  - Add 2 cycles for the synchroniser from the pin edge.

Test Plan (SCAN_DIV=4, DEB_N=3 unless stated):
- Reset: hold rst_n=0 with col=4'b0000 → row=1110, key_code=0, key_valid=0, key_held=0. After release with col=1111, row steps 1110→1101→1011→0111→1110 every 4 cycles.
- Clean press of row 2, col 1 (col line 1 low only while row=1011):
  - Scanning stops at row=1011.
  - key_valid pulses once, exactly 9 cycles after the detecting tick.
  - key_code=9, key_held=1.
- Release: col returns to 1111 → key_held falls after 3 idle ticks, key_code stays 9, row resumes rotating from row 3.
- Bounce during press: col line 1 low for 1 tick, high for 1 tick, then stable → first attempt abandoned, no strobe. Accepted only after 3 consecutive matching ticks. Exactly one key_valid pulse total.
- Multi-key: col=4'b1001 on row 0 → treated as idle, no strobe, rotation continues. Separately, press key 5 then also key 0 while held → no second strobe until both are released and a new press is debounced.
- Reset mid-operation: assert rst_n=0 during DEB_PRESS after 2 matches → no key_valid, outputs return to reset values. After release, the same stable key is accepted 9 cycles after its first detecting tick, with the row counted from 0.
